bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter; the inverse path of the binary-to-BCD display chain. It takes a packed multi-digit BCD value, for example from a keypad or digit-entry logic that edits the displayed number, and produces the binary value for the 18-bit datapath. It uses one multiply-by-10-and-add step per digit, driven by a start/busy/valid handshake. It also flags invalid digits and results that overflow the output width.

Parameters:
DIGITS, 6, number of BCD digits in bcd_in; the most-significant digit is in the top nibble.
OUT_W, 18, binary output width; matches the display input width.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request conversion; sampled only in IDLE.
bcd_in  input  4*DIGITS  packed BCD digits; digit k is bcd_in[4k+3:4k].
busy  output  1  high from the cycle after start is accepted until valid is asserted.
valid  output  1  one-cycle pulse; bin_out, error and overflow are updated in the same cycle.
bin_out  output  OUT_W  converted value; held until the next valid.
error  output  1  the last result contained a digit > 9; held with bin_out.
overflow  output  1  the last result exceeded 2^OUT_W-1; held with bin_out.

Behaviour:
- Reset (reset=0, asynchronous):
  - state returns to IDLE.
  - busy, valid, error and overflow go to 0.
  - bin_out goes to 0.
  - internal accumulator and digit counter are cleared.
  - Reset asserted mid-conversion aborts the conversion with no valid pulse.
- States: IDLE, CHECK, CONVERT, DONE.
- IDLE:
  - busy=0.
  - On the edge where start=1: capture bcd_in into a shadow register, set acc=0 and cnt=0, go to CHECK.
  - Later changes to bcd_in do not affect an accepted conversion.
- CHECK (one cycle):
  - If any captured digit > 9, go to DONE with res_err=1.
  - Otherwise go to CONVERT.
- CONVERT (exactly DIGITS cycles, MSD first):
  - Each edge: acc_next = acc*10 + digit[DIGITS-1-cnt]; cnt increments.
  - acc*10 is formed as (acc<<3)+(acc<<1); no multiplier is used.
  - acc is OUT_W+4 bits wide.
  - If acc_next > 2^OUT_W-1: set sticky ovf and clamp acc to 2^OUT_W-1.
  - When cnt reaches DIGITS-1 on an edge, go to DONE.
- Transition into DONE (registered), valid=1 for one cycle:
  - bin_out = 0 if res_err.
  - Otherwise bin_out = all-ones if ovf.
  - Otherwise bin_out = acc[OUT_W-1:0].
  - error=res_err, overflow=ovf.
- DONE (one cycle): next edge returns to IDLE, valid=0, busy=0.
- Latency, counting the edge that samples start as edge 0:
  - Normal path: valid high after edge DIGITS+1, i.e. 7 edges for the default.
  - Error path: valid high after edge 1.
- Handshake:
  - busy=1 in CHECK and CONVERT.
  - start while busy or in DONE is ignored; it is not queued.
  - start held high continuously starts a new conversion on the first IDLE edge after DONE, so there is one idle cycle between results.
- Outputs are registered; there is no combinational path from start or bcd_in to any output.
- Leading zero digits are legal and produce no special case.
- Boundary values:
  - All-zero input gives bin_out=0 with valid.
  - All-nine input with OUT_W >= 20 gives 999999 with no overflow.

Test Plan:
- Defaults, bcd_in=0x123456, start pulse -> busy high for 7 cycles; valid pulse after edge 7; bin_out=0x1E240, error=0, overflow=0.
- bcd_in=0x262143 -> bin_out=0x3FFFF, overflow=0. Then bcd_in=0x262144 -> bin_out=0x3FFFF, overflow=1. Then bcd_in=0x999999 -> overflow=1.
- bcd_in=0x00A012 -> valid after edge 1; error=1, bin_out=0, overflow=0. A following bcd_in=0x000000 conversion clears error and returns bin_out=0.
- Start accepted with 0x000042, then start pulsed and bcd_in changed to 0x999999 during CONVERT -> exactly one valid; bin_out=0x2A.
- reset=0 asserted in CONVERT cycle 3 -> outputs 0 immediately (asynchronous) and no valid. After release, a start with 0x000010 -> bin_out=0x0A.
- start held high for 20 cycles with bcd_in=0x000001 -> valid pulses repeat every 9 cycles (7 latency + DONE + IDLE); bin_out=1 each time.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one multiply-by-10-and-add step per digit, MSD first,
// with a start/busy/valid handshake and flags for invalid digits and output overflow.
module bcd2bin_seq #(
    parameter int unsigned DIGITS = 6,
    parameter int unsigned OUT_W  = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  valid,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  error,
    output logic                  overflow
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned ACC_W = OUT_W + 4;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {OUT_W{1'b1}}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CHECK   = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state, state_d;
    logic [BCD_W-1:0] shadow, shadow_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             ovf, ovf_d;
    logic             busy_d, valid_d, error_d, overflow_d;
    logic [OUT_W-1:0] bin_out_d;

    logic [BCD_W-1:0] shifted;
    logic [3:0]       digit;
    logic             bad_digit;
    logic [ACC_W-1:0] acc_mul;

    // Current digit: shift the consumed digits out so the next one sits in the top nibble.
    always_comb begin
        shifted = shadow << {cnt, 2'b00};
        digit   = shifted[BCD_W-1 -: 4];
        acc_mul = (acc << 3) + (acc << 1) + ACC_W'(digit);
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (shadow[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state;
        shadow_d   = shadow;
        acc_d      = acc;
        cnt_d      = cnt;
        ovf_d      = ovf;
        busy_d     = busy;
        valid_d    = 1'b0;
        bin_out_d  = bin_out;
        error_d    = error;
        overflow_d = overflow;

        case (state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shadow_d = bcd_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_digit) begin
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    valid_d    = 1'b1;
                    bin_out_d  = '0;
                    error_d    = 1'b1;
                    overflow_d = 1'b0;
                end else begin
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // Clamping keeps acc*10+9 inside ACC_W bits on every later step.
                if (acc_mul > ACC_MAX) begin
                    acc_d = ACC_MAX;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = acc_mul;
                end
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIGITS - 1)) begin
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    valid_d    = 1'b1;
                    error_d    = 1'b0;
                    overflow_d = ovf_d;
                    bin_out_d  = ovf_d ? {OUT_W{1'b1}} : acc_d[OUT_W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            shadow   <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            bin_out  <= '0;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            shadow   <= shadow_d;
            acc      <= acc_d;
            cnt      <= cnt_d;
            ovf      <= ovf_d;
            busy     <= busy_d;
            valid    <= valid_d;
            bin_out  <= bin_out_d;
            error    <= error_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: an arithmetic reference with a cycle-timeline model,
// directed boundary cases and randomized conversions.
module tb_bcd2bin_seq;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned OUT_W  = 18;
    localparam longint     MAXV   = (64'd1 << OUT_W) - 1;

    logic              clk;
    logic              reset;
    logic              start;
    logic [4*DIGITS-1:0] bcd_in;
    logic              busy;
    logic              valid;
    logic [OUT_W-1:0]  bin_out;
    logic              error;
    logic              overflow;

    int tests;
    int fails;

    bcd2bin_seq #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bcd_in   (bcd_in),
        .busy     (busy),
        .valid    (valid),
        .bin_out  (bin_out),
        .error    (error),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion from decimal place values.
    task automatic ref_conv(input logic [4*DIGITS-1:0] b, output logic [OUT_W-1:0] v,
                            output logic e, output logic o);
        longint val;
        logic [3:0] d;
        val = 0;
        e   = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            if (d > 4'd9) e = 1'b1;
            val = val * 10 + longint'(d);
        end
        if (e) begin
            v = '0;
            o = 1'b0;
        end else if (val > MAXV) begin
            v = '1;
            o = 1'b1;
        end else begin
            v = OUT_W'(val);
            o = 1'b0;
        end
    endtask

    // Timeline model: after an accepted start, the result appears a fixed number of edges later,
    // followed by one edge on which start cannot be accepted.
    int               cd;
    bit               hold;
    logic             exp_busy, exp_valid, exp_err, exp_ovf;
    logic [OUT_W-1:0] exp_bin;
    logic [OUT_W-1:0] p_bin;
    logic             p_err, p_ovf;
    bit               cmp_en;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cd = 0; hold = 0;
            exp_busy = 0; exp_valid = 0; exp_err = 0; exp_ovf = 0; exp_bin = '0;
        end else begin
            exp_valid = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    exp_valid = 1; exp_busy = 0;
                    exp_bin = p_bin; exp_err = p_err; exp_ovf = p_ovf;
                    hold = 1;
                end
            end else if (hold) begin
                hold = 0;
            end else if (start) begin
                ref_conv(bcd_in, p_bin, p_err, p_ovf);
                cd = p_err ? 1 : int'(DIGITS) + 1;
                exp_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset && cmp_en) begin
            chk("cyc_busy", 32'(busy), 32'(exp_busy));
            chk("cyc_valid", 32'(valid), 32'(exp_valid));
            chk("cyc_bin_out", 32'(bin_out), 32'(exp_bin));
            chk("cyc_error", 32'(error), 32'(exp_err));
            chk("cyc_overflow", 32'(overflow), 32'(exp_ovf));
        end
    end

    // One conversion with literal expectations for result and latency.
    task automatic convert(input logic [4*DIGITS-1:0] b, input logic [OUT_W-1:0] eb,
                           input logic ee, input logic eo, input int elat);
        int n;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = b;
        @(negedge clk);
        start  = 1'b0;
        n = 0;
        while (!valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lit_latency", 32'(n), 32'(elat));
        chk("lit_bin_out", 32'(bin_out), 32'(eb));
        chk("lit_error", 32'(error), 32'(ee));
        chk("lit_overflow", 32'(overflow), 32'(eo));
    endtask

    initial begin
        logic [OUT_W-1:0] rv;
        logic re, ro;
        int n, nv, vidx[3];
        logic [4*DIGITS-1:0] rb;

        tests = 0; fails = 0; cmp_en = 0;
        reset = 1'b0; start = 1'b0; bcd_in = '0;

        // Pin the reference itself.
        ref_conv(24'h123456, rv, re, ro);
        chk("ref_123456", 32'(rv), 32'h1E240);
        ref_conv(24'h262144, rv, re, ro);
        chk("ref_262144_ovf", 32'(ro), 32'd1);
        ref_conv(24'h00A012, rv, re, ro);
        chk("ref_00A012_err", 32'(re), 32'd1);

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_flags", 32'({error, overflow}), 32'd0);
        reset  = 1'b1;
        cmp_en = 1;

        convert(24'h123456, 18'h1E240, 1'b0, 1'b0, 7);
        convert(24'h262143, 18'h3FFFF, 1'b0, 1'b0, 7);
        convert(24'h262144, 18'h3FFFF, 1'b0, 1'b1, 7);
        convert(24'h999999, 18'h3FFFF, 1'b0, 1'b1, 7);
        convert(24'h00A012, 18'h00000, 1'b1, 1'b0, 1);
        convert(24'h000000, 18'h00000, 1'b0, 1'b0, 7);

        // Start again mid-conversion with a new value: ignored.
        @(negedge clk);
        start = 1'b1; bcd_in = 24'h000042;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; bcd_in = 24'h999999;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            if (valid) begin
                nv++;
                chk("ignore_bin_out", 32'(bin_out), 32'h2A);
            end
            @(negedge clk);
        end
        chk("ignore_valid_count", 32'(nv), 32'd1);

        // Asynchronous reset in the middle of a conversion.
        start = 1'b1; bcd_in = 24'h000042;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_bin_out", 32'(bin_out), 32'd0);
        chk("async_flags", 32'({valid, error, overflow}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        convert(24'h000010, 18'h0000A, 1'b0, 1'b0, 7);

        // Start held high: back-to-back conversions with one idle cycle between.
        @(negedge clk);
        start = 1'b1; bcd_in = 24'h000001;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid) begin
                if (nv < 3) vidx[nv] = i;
                nv++;
                chk("held_bin_out", 32'(bin_out), 32'd1);
            end
            if (i == 19) start = 1'b0;
        end
        chk("held_valid_count", 32'(nv), 32'd3);
        if (nv == 3) begin
            chk("held_first", 32'(vidx[0]), 32'd7);
            chk("held_gap1", 32'(vidx[1] - vidx[0]), 32'd9);
            chk("held_gap2", 32'(vidx[2] - vidx[1]), 32'd9);
        end
        repeat (3) @(negedge clk);

        // Randomized conversions, with stray start pulses while busy.
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int k = 0; k < int'(DIGITS); k++) begin
                rb[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                            : 4'($urandom_range(0, 9));
            end
            start = 1'b1; bcd_in = rb;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!valid && n < 40) begin
                start  = ($urandom_range(0, 3) == 0);
                bcd_in = 24'($urandom);
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            chk("rand_valid_seen", 32'(valid), 32'd1);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
